// File: rtl/neuron_loader_pkg.sv
// Shared types for the neuron loader: FSM encoding and stream word count.
package neuron_loader_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Words per neuron load excluding the trailing bias word.
  function automatic int word_count(input int num_input);
    return 2 * num_input;
  endfunction

endpackage

// File: rtl/neuron_loader_controller.sv
// Loader FSM and word-index counter; emits handshakes, neuron control and
// write strobes for the packing/result registers held by the top level.
module neuron_loader_controller
  import neuron_loader_pkg::*;
#(
  parameter int NUM_INPUT = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic             neuron_ready_i,
  input  logic             out_ready_i,
  output logic             in_ready_o,
  output logic             neuron_rst_o,
  output logic             neuron_en_o,
  output logic             out_valid_o,
  output logic             data_we_o,
  output logic             weight_we_o,
  output logic             bias_we_o,
  output logic             result_we_o,
  output logic [CNT_W-1:0] idx_o
);

  localparam logic [CNT_W-1:0] NI   = CNT_W'(NUM_INPUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(word_count(NUM_INPUT));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      LOAD: if (in_valid_i) begin
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = START;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      START: state_d = RUN;
      // Only the first high sample matters: leaving RUN ignores later ones.
      RUN:   if (neuron_ready_i) state_d = OUT;
      OUT:   if (out_ready_i) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    in_ready_o   = (state_q == LOAD);
    neuron_rst_o = rst | (state_q == START);
    neuron_en_o  = (state_q == RUN);
    out_valid_o  = (state_q == OUT);
    data_we_o    = in_ready_o && in_valid_i && (idx_q < NI);
    weight_we_o  = in_ready_o && in_valid_i && (idx_q >= NI) && (idx_q < LAST);
    bias_we_o    = in_ready_o && in_valid_i && (idx_q == LAST);
    result_we_o  = neuron_en_o && neuron_ready_i;
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/neuron_loader.sv
// Serial-to-parallel feeder for one neuron: packs data/weights/bias words,
// runs the neuron once and returns its result over a valid/ready stream.
module neuron_loader
  import neuron_loader_pkg::*;
#(
  parameter int N               = 8,
  parameter int NUM_INPUT       = 4,
  parameter int CLOG2_NUM_INPUT = 2,
  parameter int CNT_W           = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NUM_INPUT*N-1:0] datas,
  output logic [NUM_INPUT*N-1:0] weights,
  output logic [N-1:0]           bias,
  output logic                   neuron_rst,
  output logic                   neuron_en,
  input  logic [N-1:0]           neuron_result,
  input  logic                   neuron_ready,
  output logic [N-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam logic [CNT_W-1:0] NI = CNT_W'(NUM_INPUT);

  logic             data_we, weight_we, bias_we, result_we;
  logic [CNT_W-1:0] idx, lane_sel;
  logic [N-1:0]     bias_q, out_data_q;

  neuron_loader_controller #(
    .NUM_INPUT (NUM_INPUT),
    .CNT_W     (CNT_W)
  ) u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .in_valid_i     (in_valid),
    .neuron_ready_i (neuron_ready),
    .out_ready_i    (out_ready),
    .in_ready_o     (in_ready),
    .neuron_rst_o   (neuron_rst),
    .neuron_en_o    (neuron_en),
    .out_valid_o    (out_valid),
    .data_we_o      (data_we),
    .weight_we_o    (weight_we),
    .bias_we_o      (bias_we),
    .result_we_o    (result_we),
    .idx_o          (idx)
  );

  // Weight words follow the data words, so rebase idx onto a lane number.
  assign lane_sel = data_we ? idx : idx - NI;

  for (genvar i = 0; i < NUM_INPUT; i++) begin : g_lane
    localparam logic [CLOG2_NUM_INPUT-1:0] LANE = CLOG2_NUM_INPUT'(i);
    logic         hit;
    logic [N-1:0] dat_q, wgt_q;

    assign hit = (lane_sel == {{(CNT_W-CLOG2_NUM_INPUT){1'b0}}, LANE});

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dat_q <= '0;
        wgt_q <= '0;
      end else begin
        if (data_we && hit)   dat_q <= in_data;
        if (weight_we && hit) wgt_q <= in_data;
      end
    end

    assign datas[i*N +: N]   = dat_q;
    assign weights[i*N +: N] = wgt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_q     <= '0;
      out_data_q <= '0;
    end else begin
      if (bias_we)   bias_q     <= in_data;
      if (result_we) out_data_q <= neuron_result;
    end
  end

  assign bias     = bias_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_neuron_loader.sv
// Scoreboard bench for neuron_loader with a small behavioural MAC+ReLU neuron.
module tb_neuron_loader;

  localparam int LAT = 8;  // negedges from bias acceptance to out_valid

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] datas, weights;
  logic [7:0]  bias;
  logic        neuron_rst, neuron_en;
  logic [7:0]  neuron_result;
  logic        neuron_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  int          nvec = 0;
  int          nerr = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  neuron_loader #(.N(8), .NUM_INPUT(4), .CLOG2_NUM_INPUT(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .datas(datas), .weights(weights), .bias(bias),
    .neuron_rst(neuron_rst), .neuron_en(neuron_en),
    .neuron_result(neuron_result), .neuron_ready(neuron_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Behavioural neuron: one MAC per enabled cycle, then ReLU with saturation.
  function automatic logic [7:0] relu8(input int v);
    if (v < 0)   return 8'd0;
    if (v > 127) return 8'd127;
    return 8'(v);
  endfunction

  int mcnt, macc;
  always @(posedge clk) begin
    if (neuron_rst) begin
      mcnt <= 0; macc <= 0; neuron_ready <= 1'b0; neuron_result <= 8'd0;
    end else if (neuron_en && !neuron_ready) begin
      if (mcnt < 4) begin
        macc <= macc + int'($signed(datas[mcnt*8 +: 8])) * int'($signed(weights[mcnt*8 +: 8]));
        mcnt <= mcnt + 1;
      end else begin
        neuron_result <= relu8(macc + int'($signed(bias)));
        neuron_ready  <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pops on every completed output transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", {24'd0, out_data}, 32'hFFFF_FFFF);
      else chk("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic send_word(input logic [7:0] w, input bit gap);
    bit acc = 0;
    in_data = w; in_valid = 1'b1;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    if (gap) begin in_valid = 1'b0; @(posedge clk); #1; end
  endtask

  // Returns #1 after the edge that accepts the bias word; in_valid left high.
  task automatic load(input logic [31:0] d, input logic [31:0] w, input logic [7:0] b, input bit gap);
    for (int k = 0; k < 4; k++) send_word(d[k*8 +: 8], gap);
    for (int k = 0; k < 4; k++) send_word(w[k*8 +: 8], gap);
    send_word(b, 1'b0);
    in_data = 8'hEE;
  endtask

  task automatic wait_out(input string nm);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk); n++;
      if (n == 2) chk({nm, "_run_en"}, {30'd0, neuron_en, neuron_rst}, 32'd2);
      if (out_valid) seen = 1;
    end
    in_valid = 1'b0;
    if (!seen) chk({nm, "_out_timeout"}, 32'd0, 32'd1);
    else chk({nm, "_latency"}, n, LAT);
  endtask

  initial begin
    rst = 1'b1; in_data = 8'd0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_vectors", datas | weights | {24'd0, bias}, 32'd0);
    chk("rst_neuron_rst", {31'd0, neuron_rst}, 32'd1);
    chk("rst_outs", {22'd0, neuron_en, out_valid, out_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("neuron_rst_released", {31'd0, neuron_rst}, 32'd0);
    @(posedge clk); #1;

    // Basic load with in_valid held high through START/RUN.
    out_ready = 1'b1;
    load(32'h04030201, 32'h01010101, 8'd2, 1'b0);
    exp_q.push_back(8'd12);
    chk("start_cycle", {29'd0, in_ready, neuron_rst, neuron_en}, 32'b010);
    wait_out("t1");
    chk("t1_datas", datas, 32'h04030201);
    chk("t1_weights", weights, 32'h01010101);
    chk("t1_bias", {24'd0, bias}, 32'd2);
    @(negedge clk);
    chk("t1_zero_bubble", {30'd0, in_ready, out_valid}, 32'b10);
    @(posedge clk); #1;

    // Negative sum clamped by ReLU.
    load(32'h01010101, 32'hFFFFFFFF, 8'd0, 1'b0);
    exp_q.push_back(8'd0);
    wait_out("t2");
    @(posedge clk); #1;

    // Gapped in_valid.
    load(32'h04030201, 32'h01010101, 8'd2, 1'b1);
    exp_q.push_back(8'd12);
    wait_out("t3");
    chk("t3_datas", datas, 32'h04030201);
    @(posedge clk); #1;

    // Output back-pressure for 10 cycles.
    out_ready = 1'b0;
    load(32'h04030201, 32'h01010101, 8'd2, 1'b0);
    exp_q.push_back(8'd12);
    wait_out("t4");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t4_hold", {20'd0, out_data, in_ready, neuron_en, out_valid, 1'b0}, {20'd0, 8'd12, 4'b0010});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_release", {30'd0, in_ready, out_valid}, 32'b10);
    @(posedge clk); #1;

    // Reset after 5 accepted words, then a fresh load.
    for (int k = 0; k < 4; k++) send_word(8'(k + 1), 1'b0);
    send_word(8'h01, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1; #1;
    chk("t5_rst_vectors", datas | weights | {24'd0, bias}, 32'd0);
    chk("t5_rst_ctrl", {28'd0, in_ready, neuron_rst, neuron_en, out_valid}, 32'b1100);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    load(32'h04030201, 32'h01010101, 8'd2, 1'b0);
    exp_q.push_back(8'd12);
    wait_out("t5");
    @(posedge clk); #1;

    // Back-to-back vectors with out_ready tied high.
    load(32'h04030201, 32'h01010101, 8'd2, 1'b0);
    exp_q.push_back(8'd12);
    wait_out("t6a");
    @(posedge clk); #1;
    load(32'h01010101, 32'hFFFFFFFF, 8'd0, 1'b0);
    exp_q.push_back(8'd0);
    wait_out("t6b");
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
